// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the I/D cache to main-memory line arbiter.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/cache_mem_arbiter_starve_ctr.sv
// Saturating count of arbitrations the I-cache has lost to the D-cache.
module arb_starve_ctr #(
  parameter int CNT_W = 3,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic             sat_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q < LIMIT_C))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q >= LIMIT_C);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory port between I- and D-cache, one transaction at a time.
// state   | meaning
// IDLE    | memory port quiet, arbitrate pending requests
// SERVE_I | I-cache owns the memory port until pmem_resp
// SERVE_D | D-cache owns the memory port until pmem_resp
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W       = cache_arb_pkg::ADDR_W,
  parameter int LINE_W       = cache_arb_pkg::LINE_W,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        grant
);

  arb_state_e state_q, state_d;
  logic       i_pend, d_pend;
  logic       starve_inc, starve_clr, starve_sat;
  logic [CNT_W-1:0] i_starve;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  arb_starve_ctr #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (starve_clr),
    .inc_i (starve_inc),
    .sat_o (starve_sat),
    .cnt_o (i_starve)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // D wins unless I has already lost STARVE_LIMIT decisions
        if (d_pend && !(i_pend && starve_sat)) begin
          state_d    = SERVE_D;
          starve_inc = i_pend;
        end else if (i_pend) begin
          state_d    = SERVE_I;
          starve_clr = 1'b1;
        end
      end
      SERVE_I: if (pmem_resp) state_d = IDLE;
      SERVE_D: if (pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write takes precedence over an illegal simultaneous read.
  always_comb begin
    grant        = GRANT_NONE;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state_q)
      SERVE_I: begin
        grant        = GRANT_I;
        pmem_write   = i_write;
        pmem_read    = i_read & ~i_write;
        pmem_address = i_address;
        pmem_wdata   = i_wdata;
        i_resp       = pmem_resp;
      end
      SERVE_D: begin
        grant        = GRANT_D;
        pmem_write   = d_write;
        pmem_read    = d_read & ~d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed checks of the cache/memory line arbiter against hand-computed expectations.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, i_write, d_read, d_write;
  logic [31:0]  i_address, d_address, pmem_address;
  logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
  logic [1:0]   grant;

  int n_checks = 0;
  int n_errs   = 0;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_12 = {16{16'h1234}};
  localparam logic [255:0] LINE_3C = {32{8'h3C}};
  localparam logic [255:0] LINE_0F = {32{8'h0F}};

  cache_mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .grant        (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call in the first SERVE cycle; memory answers after lat extra cycles.
  task automatic mem_xfer(input string tag, input logic [1:0] g, input logic rd,
                          input logic wr, input logic [31:0] addr, input logic [255:0] wd,
                          input int lat, input logic [255:0] rdat, input logic drop);
    chk({tag, "_grant"}, 256'(grant), 256'(g));
    chk({tag, "_rd"},    256'(pmem_read), 256'(rd));
    chk({tag, "_wr"},    256'(pmem_write), 256'(wr));
    chk({tag, "_addr"},  256'(pmem_address), 256'(addr));
    chk({tag, "_wdata"}, pmem_wdata, wd);
    for (int c = 0; c < lat; c++) begin
      chk({tag, "_early_resp"}, 256'({d_resp, i_resp}), 256'(2'b00));
      step();
      chk({tag, "_addr_hold"}, 256'(pmem_address), 256'(addr));
      chk({tag, "_grant_hold"}, 256'(grant), 256'(g));
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rdat;
    #1;
    chk({tag, "_resp"},    256'({d_resp, i_resp}), 256'(g));
    chk({tag, "_i_rdata"}, i_rdata, rdat);
    chk({tag, "_d_rdata"}, d_rdata, rdat);
    step();
    pmem_resp = 1'b0;
    if (drop) begin
      if (g == 2'b10) begin d_read = 1'b0; d_write = 1'b0; end
      else            begin i_read = 1'b0; i_write = 1'b0; end
    end
    #1;
    chk({tag, "_idle_grant"}, 256'(grant), 256'(2'b00));
    chk({tag, "_idle_resp"},  256'({d_resp, i_resp}), 256'(2'b00));
  endtask

  initial begin
    rst_n = 1'b0;
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_grant", 256'(grant), 256'(2'b00));
    chk("rst_pmem",  256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(4'b0));
    chk("rst_addr",  256'(pmem_address), 256'(32'h0));

    // Reset in the middle of a D write
    d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = LINE_3C;
    step();
    chk("mid_rst_pre_wr", 256'(pmem_write), 256'(1'b1));
    pmem_resp = 1'b1;
    #1;
    chk("mid_rst_pre_resp", 256'(d_resp), 256'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr",    256'(pmem_write), 256'(1'b0));
    chk("mid_rst_resp",  256'(d_resp), 256'(1'b0));
    chk("mid_rst_grant", 256'(grant), 256'(2'b00));
    chk("mid_rst_wdata", pmem_wdata, 256'(0));
    d_write = 1'b0; pmem_resp = 1'b0; d_wdata = '0;
    #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", 256'(grant), 256'(2'b00));

    // Lone I read, memory answers in the third SERVE cycle
    i_read = 1'b1; i_address = 32'h0000_1000;
    #1;
    chk("i_lone_same_cycle", 256'(pmem_read), 256'(1'b0));
    step();
    mem_xfer("i_lone", 2'b01, 1'b1, 1'b0, 32'h0000_1000, '0, 2, LINE_A5, 1'b1);

    // Simultaneous I read and D write: D first, IDLE gap, then I
    i_read = 1'b1; i_address = 32'h0000_4000;
    d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = LINE_12;
    step();
    mem_xfer("both_d", 2'b10, 1'b0, 1'b1, 32'h0000_2000, LINE_12, 1, LINE_0F, 1'b1);
    d_wdata = '0;
    step();
    mem_xfer("both_i", 2'b01, 1'b1, 1'b0, 32'h0000_4000, '0, 0, LINE_A5, 1'b1);

    // Starvation: D requests every IDLE cycle; I must win every fifth decision
    i_read = 1'b1; i_address = 32'h0000_8000;
    d_read = 1'b1; d_address = 32'h0000_9000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        mem_xfer($sformatf("starve_r%0d_d%0d", r, k), 2'b10, 1'b1, 1'b0,
                 32'h0000_9000, '0, 0, LINE_3C, 1'b0);
      end
      step();
      mem_xfer($sformatf("starve_r%0d_i", r), 2'b01, 1'b1, 1'b0,
               32'h0000_8000, '0, 0, LINE_A5, r == 1);
    end
    d_read = 1'b0;
    step();
    chk("starve_end_idle", 256'(grant), 256'(2'b00));

    // Illegal read+write on D: only the write reaches memory
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_5000; d_wdata = LINE_0F;
    step();
    mem_xfer("illegal_rw", 2'b10, 1'b0, 1'b1, 32'h0000_5000, LINE_0F, 1, LINE_A5, 1'b1);
    d_wdata = '0;

    // D request arriving while I is being served must wait
    i_read = 1'b1; i_address = 32'h0000_6000;
    step();
    d_read = 1'b1; d_address = 32'h0000_7000;
    #1;
    mem_xfer("late_i", 2'b01, 1'b1, 1'b0, 32'h0000_6000, '0, 2, LINE_12, 1'b1);
    step();
    mem_xfer("late_d", 2'b10, 1'b1, 1'b0, 32'h0000_7000, '0, 0, LINE_3C, 1'b1);

    // Spurious pmem_resp while IDLE
    pmem_resp = 1'b1;
    #1;
    chk("spurious_resp", 256'({d_resp, i_resp}), 256'(2'b00));
    step();
    chk("spurious_grant", 256'(grant), 256'(2'b00));
    chk("spurious_resp2", 256'({d_resp, i_resp}), 256'(2'b00));
    pmem_resp = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single 256-bit line port to main memory between the instruction cache and the data cache.
- Each cache's controller side (the ca_itf role: line read/write, resp handshake) connects to one requester port.
- The arbiter sequences one full line transaction at a time onto the memory side.
- Arbitration is fixed priority (D over I) with a starvation guard for I.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cache line width (8*2**s_offset, s_offset=5)
- STARVE_LIMIT, 4, arbitration decisions I may lose before it is forced to win
- CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request
- i_write  in  1  I-cache line write request (normally 0)
- i_address  in  ADDR_W  I-cache line address (line-aligned)
- i_wdata  in  LINE_W  I-cache writeback line
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache transaction complete (1-cycle pulse)
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache writeback request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache transaction complete (1-cycle pulse)
- pmem_read  out  1  memory line read
- pmem_write  out  1  memory line write
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory transaction complete
- grant  out  2  {d_granted, i_granted}, one-hot or 0

Behaviour:

Reset:
- Async, on rst_n low; also applies mid-transaction.
- state=IDLE, i_starve=0, grant=0.
- All pmem_* outputs, i_resp and d_resp are 0 immediately.
- The memory model is reset with the arbiter; an in-flight transaction is abandoned.

Requester contract:
- A requester holds read/write/address/wdata stable from assertion until it sees its resp.
- It drops the request in the cycle after resp.
- read and write both high on one port is illegal: the arbiter forwards write and masks read.

FSM states: IDLE, SERVE_I, SERVE_D.

IDLE:
- pmem_read, pmem_write, pmem_address and pmem_wdata are 0.
- No requests pending: stay in IDLE.
- Only D pending: go to SERVE_D.
- Only I pending: go to SERVE_I.
- Both pending: go to SERVE_I if i_starve >= STARVE_LIMIT, else SERVE_D.

SERVE_x:
- grant is one-hot for x.
- pmem_read, pmem_write, pmem_address and pmem_wdata are combinationally muxed from requester x.
- The other requester's inputs are ignored.
- When pmem_resp=1: x_resp=1 in the same cycle, then go to IDLE next cycle.
- While pmem_resp=0, remain in SERVE_x; there is no timeout.

Data return:
- i_rdata = d_rdata = pmem_rdata unconditionally.
- A resp is only ever raised to the granted requester.

Latency:
- A request sampled in IDLE at cycle N drives pmem at N+1.
- The minimum turnaround is an IDLE cycle between back-to-back transactions, so a requester sees resp no earlier than N+1 (memory with 0-cycle resp).

Starvation counter (i_starve):
- Increments, saturating at STARVE_LIMIT, on each IDLE arbitration where I is pending but D is granted.
- Cleared when SERVE_I is entered.
- Unchanged otherwise.

Other rules:
- A request arriving in SERVE_x from the non-granted side waits; it is not dropped.
- A pmem_resp seen in IDLE is ignored (no resp forwarded).

Decomposition:
- Package cache_arb_pkg:
  - arb_state_e enum {IDLE, SERVE_I, SERVE_D}
  - GRANT_I=2'b01, GRANT_D=2'b10
  - LINE_W and ADDR_W constants shared with cache
- No sub-module required. The optional leaf arb_starve_ctr (saturating counter, clear/inc) is the only natural split.

Test Plan:
- Reset mid-SERVE_D: assert rst_n=0 while pmem_write=1 -> pmem_write, d_resp and grant go to 0 without waiting for clk; state is IDLE after release.
- Lone I read: i_read=1, i_address=0x0000_1000; memory responds after 3 cycles with rdata=0xA5..A5 -> pmem_read=1 with the address one cycle later, i_resp one pulse coincident with pmem_resp, i_rdata=0xA5..A5, d_resp stays 0.
- Simultaneous I read and D write (addr 0x2000, wdata 0x1234..) -> D served first (pmem_write=1, pmem_wdata=0x1234..), then IDLE, then I served; grant sequence 10, 00, 01.
- Starvation: hold i_read=1 while d_read is re-asserted continuously -> D wins 4 arbitrations, then I is granted on the 5th; i_starve returns to 0.
- Illegal d_read=d_write=1 -> only pmem_write asserted.
- Late request: d_read asserted during SERVE_I -> pmem never shows the D address until SERVE_I completes; D granted after the IDLE cycle.
- Spurious pmem_resp=1 in IDLE -> no i_resp or d_resp.
